io_oqi_serializer: RTL and testbench

- Fabric-to-pad transmit path for the AP3 IO register cell.
- Accepts 18-bit parallel words from the fabric over a valid/ready handshake and serialises each word as a 6-beat frame onto a 4-lane pad bus. The pad bus feeds the D_BUFF/OPAD chain.
- Also exports an 8-bit sent-frame count back to the fabric.
- The pad-side frame receiver is the matching deserialiser for this block.

---
 rtl/io_reg_pkg.sv | 32 +++
 rtl/io_oqi_frame_ctrl.sv | 59 +++++
 rtl/io_oqi_serializer.sv | 78 +++++++
 tb/tb_io_oqi_serializer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/io_reg_pkg.sv
// Shared frame-format constants, FSM state encodings and the beat mux helper
// for the AP3 IO register cell transmit path.
package io_reg_pkg;

  localparam int DATA_W      = 18;
  localparam int LANES       = 4;
  localparam int FRAME_BEATS = 6;
  localparam int DATA_BEATS  = FRAME_BEATS - 1;

  localparam logic [LANES-1:0] SYNC     = 4'hA;
  localparam logic [LANES-1:0] IDLE_NIB = 4'h0;
  localparam logic [2:0]       LAST_BEAT = 3'(DATA_BEATS - 1);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HDR  = 2'd1;
  localparam state_t ST_DATA = 2'd2;

  // Last data beat carries the two top bits plus even parity over the whole word.
  function automatic logic [LANES-1:0] beat_nib(input logic [DATA_W-1:0] word,
                                                input logic [2:0]        beat);
    case (beat)
      3'd0:    return word[3:0];
      3'd1:    return word[7:4];
      3'd2:    return word[11:8];
      3'd3:    return word[15:12];
      default: return {1'b0, ^word, word[17:16]};
    endcase
  endfunction

endpackage

// File: rtl/io_oqi_frame_ctrl.sv
// Frame sequencing for the OQI serializer: state register, beat counter and
// the combinational ready window (IDLE or last data beat).
module io_oqi_frame_ctrl
  import io_reg_pkg::*;
(
  input  logic       IQC,
  input  logic       QRT,
  input  logic       oqi_valid,
  output logic       oqi_ready,
  output logic       xfer,
  output logic       frame_done,
  output state_t     state,
  output state_t     state_nxt,
  output logic [2:0] beat_nxt
);

  logic [2:0] beat;

  assign frame_done = (state == ST_DATA) && (beat == LAST_BEAT);
  assign oqi_ready  = QRT && ((state == ST_IDLE) || frame_done);
  assign xfer       = oqi_valid && oqi_ready;

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    case (state)
      ST_IDLE: begin
        if (xfer) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        state_nxt = ST_DATA;
        beat_nxt  = '0;
      end
      ST_DATA: begin
        if (frame_done) begin
          state_nxt = xfer ? ST_HDR : ST_IDLE;
          beat_nxt  = '0;
        end else begin
          beat_nxt = beat + 3'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        beat_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge IQC or negedge QRT) begin
    if (!QRT) begin
      state <= ST_IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

endmodule

// File: rtl/io_oqi_serializer.sv
// Fabric-to-pad transmit path: 18-bit words become 6-beat frames (SYNC header,
// five data beats) on a 4-lane registered pad bus, with a sent-frame counter.
module io_oqi_serializer
  import io_reg_pkg::*;
(
  input  logic              IQC,
  input  logic              QRT,
  input  logic [DATA_W-1:0] oqi,
  input  logic              oqi_valid,
  output logic              oqi_ready,
  output logic [LANES-1:0]  pad_d,
  output logic              pad_frm,
  output logic [7:0]        iqz_cnt,
  output logic              busy
);

  logic              xfer;
  logic              frame_done;
  state_t            state;
  state_t            state_nxt;
  logic [2:0]        beat_nxt;
  logic [DATA_W-1:0] hold;

  io_oqi_frame_ctrl u_ctrl (
    .IQC        (IQC),
    .QRT        (QRT),
    .oqi_valid  (oqi_valid),
    .oqi_ready  (oqi_ready),
    .xfer       (xfer),
    .frame_done (frame_done),
    .state      (state),
    .state_nxt  (state_nxt),
    .beat_nxt   (beat_nxt)
  );

  assign busy = (state != ST_IDLE);

  // The hold register only loads on a real transfer, so oqi is never sampled otherwise.
  always_ff @(posedge IQC or negedge QRT) begin
    if (!QRT) begin
      hold <= '0;
    end else if (xfer) begin
      hold <= oqi;
    end
  end

  // Pad outputs are registered from the next state so they line up with the FSM.
  always_ff @(posedge IQC or negedge QRT) begin
    if (!QRT) begin
      pad_d   <= IDLE_NIB;
      pad_frm <= 1'b0;
    end else begin
      case (state_nxt)
        ST_HDR: begin
          pad_d   <= SYNC;
          pad_frm <= 1'b1;
        end
        ST_DATA: begin
          pad_d   <= beat_nib(hold, beat_nxt);
          pad_frm <= 1'b1;
        end
        default: begin
          pad_d   <= IDLE_NIB;
          pad_frm <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge IQC or negedge QRT) begin
    if (!QRT) begin
      iqz_cnt <= '0;
    end else if (frame_done) begin
      iqz_cnt <= iqz_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_io_oqi_serializer.sv
// Self-checking bench for io_oqi_serializer: a queue-of-beats reference model
// checked every cycle, plus directed frames with literal expected beats.
module tb_io_oqi_serializer;

  logic        IQC;
  logic        QRT;
  logic [17:0] oqi;
  logic        oqi_valid;
  logic        oqi_ready;
  logic [3:0]  pad_d;
  logic        pad_frm;
  logic [7:0]  iqz_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  io_oqi_serializer dut (
    .IQC       (IQC),
    .QRT       (QRT),
    .oqi       (oqi),
    .oqi_valid (oqi_valid),
    .oqi_ready (oqi_ready),
    .pad_d     (pad_d),
    .pad_frm   (pad_frm),
    .iqz_cnt   (iqz_cnt),
    .busy      (busy)
  );

  initial IQC = 1'b0;
  always #5 IQC = ~IQC;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted word expands into six pad beats in a queue;
  // bit 4 of an entry flags the final beat of a frame.
  logic [4:0] expq[$];
  logic [7:0] model_cnt = 8'd0;

  function automatic void push_frame(input logic [17:0] w);
    logic p;
    expq.push_back({1'b0, 4'hA});
    for (int k = 0; k < 4; k++) expq.push_back({1'b0, 4'((w >> (4 * k)) & 18'hF)});
    p = ($countones(w) % 2) == 1;
    expq.push_back({1'b1, 1'b0, p, w[17:16]});
  endfunction

  always @(negedge IQC) begin : model
    logic [4:0] cur;
    logic       have;
    if (!QRT) begin
      expq.delete();
      model_cnt = 8'd0;
      check_output("rst_pad_d", {28'd0, pad_d}, 32'h0);
      check_output("rst_pad_frm", {31'd0, pad_frm}, 32'h0);
      check_output("rst_ready", {31'd0, oqi_ready}, 32'h0);
      check_output("rst_cnt", {24'd0, iqz_cnt}, 32'h0);
      check_output("rst_busy", {31'd0, busy}, 32'h0);
    end else begin
      have = (expq.size() > 0);
      cur  = have ? expq.pop_front() : 5'h00;
      check_output("m_pad_d", {28'd0, pad_d}, {28'd0, cur[3:0]});
      check_output("m_pad_frm", {31'd0, pad_frm}, {31'd0, have});
      check_output("m_busy", {31'd0, busy}, {31'd0, have});
      check_output("m_cnt", {24'd0, iqz_cnt}, {24'd0, model_cnt});
      check_output("m_ready", {31'd0, oqi_ready}, {31'd0, expq.size() == 0});
      if (have && cur[4]) model_cnt = model_cnt + 8'd1;
      if (oqi_valid && expq.size() == 0) push_frame(oqi);
    end
  end

  task automatic apply_stimulus(input logic v, input logic [17:0] w);
    @(posedge IQC);
    #1;
    oqi_valid = v;
    oqi       = w;
  endtask

  // Sends one word from IDLE and checks the six beats plus the idle/count afterwards.
  task automatic run_frame(input logic [17:0] w, input logic [23:0] nibs, input logic [7:0] cnt_after);
    apply_stimulus(1'b1, w);
    apply_stimulus(1'b0, 18'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge IQC);
      check_output($sformatf("frame_%05h_beat%0d", w, i), {28'd0, pad_d}, {28'd0, nibs[23 - 4 * i -: 4]});
      check_output($sformatf("frame_%05h_frm%0d", w, i), {31'd0, pad_frm}, 32'h1);
    end
    @(negedge IQC);
    check_output("post_frame_pad_d", {28'd0, pad_d}, 32'h0);
    check_output("post_frame_frm", {31'd0, pad_frm}, 32'h0);
    check_output("post_frame_cnt", {24'd0, iqz_cnt}, {24'd0, cnt_after});
  endtask

  task automatic do_reset();
    @(posedge IQC);
    #2;
    QRT = 1'b0;
    oqi_valid = 1'b0;
    repeat (2) @(posedge IQC);
    #1;
    QRT = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    logic [23:0] b2b;
    QRT       = 1'b0;
    oqi_valid = 1'b0;
    oqi       = 18'h0;
    repeat (3) @(posedge IQC);
    #1;
    QRT = 1'b1;

    // Single word and parity cases
    run_frame(18'h25A3C, 24'hAC3A56, 8'd1);
    run_frame(18'h00001, 24'hA10004, 8'd2);
    run_frame(18'h00003, 24'hA30000, 8'd3);

    // Back-to-back with valid held high; oqi churns while ready is low
    apply_stimulus(1'b1, 18'h00000);
    for (int i = 0; i < 12; i++) begin
      @(posedge IQC);
      #1;
      if (i < 5) oqi = 18'($urandom);
      else if (i == 5) oqi = 18'h3FFFF;
      else oqi_valid = 1'b0;
      @(negedge IQC);
      b2b = (i < 6) ? 24'hA00000 : 24'hAFFFF3;
      check_output($sformatf("b2b_beat%0d", i), {28'd0, pad_d}, {28'd0, b2b[23 - 4 * (i % 6) -: 4]});
      check_output($sformatf("b2b_frm%0d", i), {31'd0, pad_frm}, 32'h1);
      if (i < 6) check_output($sformatf("b2b_ready%0d", i), {31'd0, oqi_ready}, {31'd0, i == 5});
    end
    @(negedge IQC);
    check_output("b2b_idle_frm", {31'd0, pad_frm}, 32'h0);
    check_output("b2b_cnt", {24'd0, iqz_cnt}, 32'd5);

    // Asynchronous reset during data beat 2
    apply_stimulus(1'b1, 18'h1B7E4);
    apply_stimulus(1'b0, 18'h0);
    repeat (2) @(posedge IQC);
    @(posedge IQC);
    #2;
    QRT = 1'b0;
    #1;
    check_output("async_rst_pad_d", {28'd0, pad_d}, 32'h0);
    check_output("async_rst_frm", {31'd0, pad_frm}, 32'h0);
    check_output("async_rst_cnt", {24'd0, iqz_cnt}, 32'h0);
    repeat (2) @(posedge IQC);
    #1;
    QRT = 1'b1;
    run_frame(18'h25A3C, 24'hAC3A56, 8'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      apply_stimulus($urandom_range(0, 3) != 0, 18'($urandom));
    end
    apply_stimulus(1'b0, 18'h0);
    repeat (8) @(posedge IQC);

    // Counter wrap over 256 back-to-back frames
    do_reset();
    apply_stimulus(1'b1, 18'($urandom));
    @(negedge IQC);
    @(negedge IQC);
    for (int f = 1; f <= 256; f++) begin
      oqi = 18'($urandom);
      repeat (6) @(negedge IQC);
      check_output($sformatf("wrap_cnt_f%0d", f), {24'd0, iqz_cnt}, {24'd0, 8'(f)});
    end
    apply_stimulus(1'b0, 18'h0);
    repeat (10) @(posedge IQC);
    @(negedge IQC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
